// File: rtl/tdm_pkg.sv
// tdm_pkg: shared constants and state type for the TDM serial receive path.
//   NSLOT   slots per frame, equal to the parallel word width
//   SLOT_W  slot index width, log2(NSLOT)
//   state_t frame alignment state {HUNT, LOCK}
package tdm_pkg;
    localparam int NSLOT  = 16;
    localparam int SLOT_W = 4;
    typedef enum logic {HUNT, LOCK} state_t;
endpackage

// File: rtl/tdm_demux16_demux1x16.sv
// demux1x16: combinational 1-to-16 one-hot decoder, the inverse of the transmit 16:1 mux.
//   sel  in   slot index
//   en   out  one-hot enable, en[sel]=1
module demux1x16
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0] sel,
    output logic [NSLOT-1:0]  en
);
    always_comb en = NSLOT'(1) << sel;
endmodule

// File: rtl/tdm_demux16.sv
// tdm_demux16: rebuilds 16-bit words from a TDM serial stream aligned by a slot-0 frame sync.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_bit    serial beat strobe and data bit
//   frame_sync          marks the slot-0 beat (qualified by in_valid)
//   out, out_valid      last complete frame, one-cycle update strobe
//   sel                 slot index expected on the next accepted beat
//   locked, frame_err   alignment status, one-cycle framing-violation pulse
module tdm_demux16
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              frame_sync,
    output logic [NSLOT-1:0]  out,
    output logic              out_valid,
    output logic [SLOT_W-1:0] sel,
    output logic              locked,
    output logic              frame_err
);
    state_t            state, state_nx;
    logic [SLOT_W-1:0] cnt, cnt_nx, addr;
    logic [NSLOT-1:0]  shadow, out_nx, dec, en;
    logic              wr, ov_nx, fe_nx;

    // A sync beat always lands in slot 0, even when it interrupts a frame.
    assign addr   = frame_sync ? '0 : cnt;
    assign en     = dec & {NSLOT{wr}};
    assign sel    = cnt;
    assign locked = (state == LOCK);

    demux1x16 u_dec (
        .sel (addr),
        .en  (dec)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        out_nx   = out;
        ov_nx    = 1'b0;
        fe_nx    = 1'b0;
        wr       = 1'b0;
        if (in_valid) begin
            if (state == HUNT) begin
                if (frame_sync) begin
                    wr       = 1'b1;
                    cnt_nx   = SLOT_W'(1);
                    state_nx = LOCK;
                end
            end else if (frame_sync) begin
                wr     = 1'b1;
                cnt_nx = SLOT_W'(1);
                fe_nx  = (cnt != '0);
            end else if (cnt == '0) begin
                fe_nx    = 1'b1;
                state_nx = HUNT;
            end else begin
                wr     = 1'b1;
                cnt_nx = cnt + SLOT_W'(1);
                if (cnt == SLOT_W'(NSLOT-1)) begin
                    out_nx = {in_bit, shadow[NSLOT-2:0]};
                    ov_nx  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            cnt       <= '0;
            shadow    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shadow    <= (shadow & ~en) | (en & {NSLOT{in_bit}});
            out       <= out_nx;
            out_valid <= ov_nx;
            frame_err <= fe_nx;
        end
    end
endmodule

// File: tb/tb_tdm_demux16.sv
// tb_tdm_demux16: self-checking bench for tdm_demux16 with a queue-based frame model.
module tb_tdm_demux16;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_bit = 1'b0, frame_sync = 1'b0;
    logic [15:0] out;
    logic        out_valid, locked, frame_err;
    logic [3:0]  sel;
    int          total = 0, bad = 0, ov_cnt = 0, fe_cnt = 0, cyc = 0, last_ov = 0, ov_gap = 0;
    bit          m_lock = 0;
    bit          q[$];
    logic [15:0] m_out = '0;
    logic        m_ov = 0, m_fe = 0;

    typedef struct {
        logic [15:0] word;
        bit          idle;
        int          exp_gap;
        logic [15:0] exp_out;
    } vec_t;
    vec_t tbl[4];

    tdm_demux16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .frame_sync (frame_sync),
        .out        (out),
        .out_valid  (out_valid),
        .sel        (sel),
        .locked     (locked),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic s);
        in_valid = v; in_bit = b; frame_sync = s;
        @(posedge clk); #1;
        cyc++;
        m_ov = 0; m_fe = 0;
        if (v) begin
            if (!m_lock) begin
                if (s) begin q = {b}; m_lock = 1; end
            end else if (s) begin
                m_fe = (q.size() != 0);
                q = {b};
            end else if (q.size() == 0) begin
                m_fe = 1; m_lock = 0;
            end else begin
                q.push_back(b);
                if (q.size() == 16) begin
                    foreach (q[i]) m_out[i] = q[i];
                    m_ov = 1;
                    q = {};
                end
            end
        end
        if (out_valid) begin ov_cnt++; ov_gap = cyc - last_ov; last_ov = cyc; end
        if (frame_err) fe_cnt++;
        chk("out", out, m_out);
        chk("out_valid", 16'(out_valid), 16'(m_ov));
        chk("frame_err", 16'(frame_err), 16'(m_fe));
        chk("sel", 16'(sel), 16'(q.size()));
        chk("locked", 16'(locked), 16'(m_lock));
    endtask

    task automatic send_frame(input logic [15:0] w, input bit idle);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, w[i], i == 0);
            if (idle) step(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        tbl[0] = '{16'hA5A5, 1'b0, 0,  16'hA5A5};
        tbl[1] = '{16'h1234, 1'b0, 16, 16'h1234};
        tbl[2] = '{16'hBEEF, 1'b1, 0,  16'hBEEF};
        tbl[3] = '{16'h8001, 1'b1, 0,  16'h8001};

        #12;
        chk("rst_out", out, 16'h0);
        chk("rst_flags", {12'b0, out_valid, frame_err, locked, 1'b0}, 16'h0);
        chk("rst_sel", 16'(sel), 16'h0);
        #1 rst_n = 1'b1;

        ov_cnt = 0; fe_cnt = 0;
        send_frame(16'h0F85, 1'b0);
        chk("first_out", out, 16'h0F85);
        chk("first_ov_cnt", 16'(ov_cnt), 16'd1);
        chk("first_locked", 16'(locked), 16'd1);
        chk("first_sel", 16'(sel), 16'd0);

        foreach (tbl[k]) begin
            ov_cnt = 0; fe_cnt = 0;
            send_frame(tbl[k].word, tbl[k].idle);
            chk("tbl_out", out, tbl[k].exp_out);
            chk("tbl_ov_cnt", 16'(ov_cnt), 16'd1);
            chk("tbl_fe_cnt", 16'(fe_cnt), 16'd0);
            if (tbl[k].exp_gap != 0) chk("tbl_gap", 16'(ov_gap), 16'(tbl[k].exp_gap));
        end

        ov_cnt = 0; fe_cnt = 0;
        for (int i = 0; i < 9; i++) step(1'b1, 1'($urandom), i == 0);
        chk("early_no_ov", 16'(ov_cnt), 16'd0);
        send_frame(16'h00FF, 1'b0);
        chk("early_fe_cnt", 16'(fe_cnt), 16'd1);
        chk("early_ov_cnt", 16'(ov_cnt), 16'd1);
        chk("early_out", out, 16'h00FF);

        step(1'b1, 1'b1, 1'b0);
        chk("miss_fe", 16'(frame_err), 16'd1);
        chk("miss_locked", 16'(locked), 16'd0);
        fe_cnt = 0;
        for (int i = 0; i < 20; i++) step(1'($urandom), 1'($urandom), 1'b0);
        chk("hunt_no_fe", 16'(fe_cnt), 16'd0);
        send_frame(16'hC3C3, 1'b0);
        chk("relock_out", out, 16'hC3C3);
        chk("relock_locked", 16'(locked), 16'd1);

        for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), i == 0);
        chk("pre_rst_sel", 16'(sel), 16'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out", out, 16'h0);
        chk("arst_flags", {12'b0, out_valid, frame_err, locked, 1'b0}, 16'h0);
        chk("arst_sel", 16'(sel), 16'h0);
        q = {}; m_lock = 0; m_out = '0;
        #2 rst_n = 1'b1;
        ov_cnt = 0;
        send_frame(16'h5555, 1'b0);
        chk("post_rst_out", out, 16'h5555);
        chk("post_rst_ov_cnt", 16'(ov_cnt), 16'd1);

        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 14) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Receive-side counterpart of the 16:1 bit multiplexer used on the transmit side of the time-division serial link.
- Transmit side walks a 4-bit select across 16 parallel inputs and emits one bit per beat.
- This block rebuilds the 16-bit parallel word from that serial stream, using a frame-sync marker on slot 0.
- It tracks frame alignment, presents each completed word with a one-cycle valid strobe, and flags framing errors.

Parameters:
- NSLOT, 16, slots per frame; fixed power of two, equals parallel word width.
- SLOT_W, 4, slot index width, log2(NSLOT).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  one serial beat is present this cycle.
- in_bit  input  1  serial data bit; meaningful only when in_valid=1.
- frame_sync  input  1  marks the slot-0 beat; qualified by in_valid.
- out  output  NSLOT  last complete frame; out[i] is the bit from slot i.
- out_valid  output  1  one-cycle pulse when out is updated.
- sel  output  SLOT_W  slot index expected on the next accepted beat.
- locked  output  1  1 while the FSM is in LOCK.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Reset (asynchronous, rst_n=0): state=HUNT, slot counter=0, shadow=0, out=0, out_valid=0, frame_err=0, locked=0, sel=0. Reset asserted mid-frame discards any partial frame.
- A beat is accepted only when in_valid=1. With in_valid=0, all state holds and both pulse outputs drop to 0.
- HUNT state:
  - Accepted beats without frame_sync are discarded; no error is raised.
  - An accepted beat with frame_sync writes shadow[0]=in_bit, sets the counter to 1 and moves to LOCK.
- LOCK state, accepted beat, frame_sync=0, counter=c with 1<=c<=14: shadow[c]=in_bit; counter becomes c+1.
- LOCK state, accepted beat, frame_sync=0, counter=15:
  - out={in_bit, shadow[14:0]}; out_valid=1 for one cycle.
  - Counter wraps to 0.
  - out and out_valid are registered on the same edge that samples the slot-15 bit, so they are visible the following cycle.
- LOCK state, accepted beat, frame_sync=1, counter=0: this is normal frame start. shadow[0]=in_bit; counter becomes 1.
- LOCK state, accepted beat, frame_sync=1, counter!=0 (early sync):
  - frame_err=1 for one cycle; the partial frame is discarded and out is unchanged.
  - The beat is taken as a new slot 0: shadow[0]=in_bit, counter=1, state stays LOCK.
- LOCK state, accepted beat, frame_sync=0, counter=0 (missing sync):
  - frame_err=1 for one cycle; the beat is discarded.
  - State goes to HUNT and the counter stays 0.
- Simultaneous events: frame_sync on the slot-15 beat is an early-sync error. out_valid and frame_err are never high together.
- Shadow write enables are one-hot, decoded from the counter; only the addressed shadow bit changes.
- sel always equals the counter. locked equals (state==LOCK).
- Throughput is one bit per accepted beat. Back-to-back frames at in_valid=1 continuously give out_valid once every 16 cycles.

Decomposition:
- Package tdm_pkg contains:
  - NSLOT and SLOT_W constants.
  - State enum {HUNT, LOCK}.
- Sub-module demux1x16: combinational 1-to-16 decoder (4-bit sel in, 16-bit one-hot enable out). It is the structural inverse of the transmit multiplexer and is instantiated once to drive the shadow write enables.

Test Plan:
- Reset, then 16 continuous beats with sync on beat 0 and bits 1,0,1,0,0,0,0,1,1,1,1,1,0,0,0,0 (slot0 first) -> exactly one out_valid pulse, out=16'h0F85, locked=1, sel=0 afterwards.
- Two back-to-back frames, 16'hA5A5 then 16'h1234, with in_valid=1 throughout -> out_valid pulses 16 cycles apart; out reads A5A5 then 1234; frame_err never asserted.
- in_valid toggling 1,0,1,0 across a frame carrying 16'hBEEF -> single out_valid; out=16'hBEEF; sel holds during the idle cycles.
- frame_sync reasserted at slot 9, then a full 16'h00FF frame -> frame_err pulse at the slot-9 beat; no out_valid for the aborted frame; next out=16'h00FF.
- After a complete frame, next beat arrives without sync -> frame_err pulse, locked=0. Random beats without sync follow -> no further errors. Sync plus frame 16'hC3C3 -> relock, out=16'hC3C3.
- rst_n driven low asynchronously at slot 7 -> all outputs zero immediately. After release, a full 16'h5555 frame -> out=16'h5555 with no stale bits.
